// File: rtl/id_ctrl_if.sv
// ---------------------------------------------------------------------------
// id_ctrl_if -- bundle of every non-clock/reset signal of the ID/EX control
// stage.
//   Upstream (IF/ID) side : in_valid, in_ready, inst, pc, flush
//   Downstream (EX) side  : out_ready, out_valid and the registered control
//                           bundle out_*
//   Status                : err_sticky, bubble_cnt
// The "master" modport is the surrounding pipeline (or a testbench).
// The "slave" modport is id_ctrl_stage.
// ---------------------------------------------------------------------------
interface id_ctrl_if #(
    parameter int XLEN     = 32,
    parameter int ALU_OP_W = 4,
    parameter int CNT_W    = 16
);
    logic                in_valid;
    logic                in_ready;
    logic [31:0]         inst;
    logic [XLEN-1:0]     pc;
    logic                flush;
    logic                out_ready;
    logic                out_valid;
    logic [XLEN-1:0]     out_pc;
    logic [4:0]          out_rs1;
    logic [4:0]          out_rs2;
    logic [4:0]          out_rd;
    logic [1:0]          out_npc_op;
    logic                out_rf_we;
    logic [1:0]          out_wd_sel;
    logic                out_alua_pc;
    logic [2:0]          out_sext_op;
    logic [ALU_OP_W-1:0] out_alu_op;
    logic                out_alub_sel;
    logic                out_branch;
    logic [2:0]          out_br_type;
    logic                out_mem_re;
    logic                out_mem_we;
    logic [2:0]          out_mem_size;
    logic                out_illegal;
    logic                err_sticky;
    logic [CNT_W-1:0]    bubble_cnt;

    modport master (
        output in_valid, inst, pc, flush, out_ready,
        input  in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd,
               out_npc_op, out_rf_we, out_wd_sel, out_alua_pc, out_sext_op,
               out_alu_op, out_alub_sel, out_branch, out_br_type,
               out_mem_re, out_mem_we, out_mem_size, out_illegal,
               err_sticky, bubble_cnt
    );

    modport slave (
        input  in_valid, inst, pc, flush, out_ready,
        output in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd,
               out_npc_op, out_rf_we, out_wd_sel, out_alua_pc, out_sext_op,
               out_alu_op, out_alub_sel, out_branch, out_br_type,
               out_mem_re, out_mem_we, out_mem_size, out_illegal,
               err_sticky, bubble_cnt
    );
endinterface

// File: rtl/id_ctrl_stage.sv
// ---------------------------------------------------------------------------
// id_ctrl_stage -- RV32I(+M) decode stage with registered ID/EX control
// bundle.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : id_ctrl_if.slave (handshake in, instruction/pc in, flush,
//                registered control bundle out, sticky illegal flag,
//                saturating load-use bubble counter)
// Decode is combinational; the bundle is registered with a valid/ready
// handshake, flush, and a single-bubble load-use interlock. Undecodable
// words (including M ops when RV_M=0, FENCE and SYSTEM) become a NOP
// bundle carrying out_illegal=1. Bubbles and flushes load an all-zero bundle.
// ---------------------------------------------------------------------------
module id_ctrl_stage #(
    parameter int XLEN     = 32,
    parameter int ALU_OP_W = 4,
    parameter int RV_M     = 0,
    parameter int CNT_W    = 16
) (
    input logic     clk,
    input logic     rst_n,
    id_ctrl_if.slave bus
);
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [ALU_OP_W-1:0] ALU_ADD  = ALU_OP_W'(4'd0);
    localparam logic [ALU_OP_W-1:0] ALU_SUB  = ALU_OP_W'(4'd1);
    localparam logic [ALU_OP_W-1:0] ALU_AND  = ALU_OP_W'(4'd2);
    localparam logic [ALU_OP_W-1:0] ALU_OR   = ALU_OP_W'(4'd3);
    localparam logic [ALU_OP_W-1:0] ALU_XOR  = ALU_OP_W'(4'd4);
    localparam logic [ALU_OP_W-1:0] ALU_SLL  = ALU_OP_W'(4'd5);
    localparam logic [ALU_OP_W-1:0] ALU_SRL  = ALU_OP_W'(4'd6);
    localparam logic [ALU_OP_W-1:0] ALU_SRA  = ALU_OP_W'(4'd7);
    localparam logic [ALU_OP_W-1:0] ALU_SLT  = ALU_OP_W'(4'd8);
    localparam logic [ALU_OP_W-1:0] ALU_SLTU = ALU_OP_W'(4'd9);
    localparam logic [ALU_OP_W-1:0] ALU_MUL  = ALU_OP_W'(4'd10);
    localparam logic [ALU_OP_W-1:0] ALU_MULH = ALU_OP_W'(4'd11);
    localparam logic [ALU_OP_W-1:0] ALU_DIV  = ALU_OP_W'(4'd12);
    localparam logic [ALU_OP_W-1:0] ALU_DIVU = ALU_OP_W'(4'd13);
    localparam logic [ALU_OP_W-1:0] ALU_REM  = ALU_OP_W'(4'd14);
    localparam logic [ALU_OP_W-1:0] ALU_REMU = ALU_OP_W'(4'd15);

    typedef struct packed {
        logic [XLEN-1:0]     pc;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [4:0]          rd;
        logic [1:0]          npc_op;
        logic                rf_we;
        logic [1:0]          wd_sel;
        logic                alua_pc;
        logic [2:0]          sext_op;
        logic [ALU_OP_W-1:0] alu_op;
        logic                alub_sel;
        logic                branch;
        logic [2:0]          br_type;
        logic                mem_re;
        logic                mem_we;
        logic [2:0]          mem_size;
        logic                illegal;
    } bundle_t;

    // Shared funct3 -> ALU op map of the register and immediate ALU groups.
    function automatic logic [ALU_OP_W-1:0] base_alu(input logic [2:0] f3);
        logic [ALU_OP_W-1:0] op;
        case (f3)
            3'b000:  op = ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = ALU_SRL;
            3'b110:  op = ALU_OR;
            3'b111:  op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

    logic [6:0] opcode_s;
    logic [2:0] f3_s;
    logic [6:0] f7_s;
    logic       legal_s;
    logic       hz_s;
    bundle_t    dec_s;
    bundle_t    bun_r;
    logic       valid_r;
    logic       err_r;
    logic [CNT_W-1:0] cnt_r;

    assign opcode_s = bus.inst[6:0];
    assign f3_s     = bus.inst[14:12];
    assign f7_s     = bus.inst[31:25];

    // Combinational decode of the incoming word; unused register fields stay 0,
    // which also lets the hazard check compare them directly.
    always_comb begin
        dec_s   = '0;
        legal_s = 1'b0;
        case (opcode_s)
            OPC_LUI: begin
                legal_s = 1'b1; dec_s.rd = bus.inst[11:7]; dec_s.rf_we = 1'b1;
                dec_s.wd_sel = 2'b11; dec_s.sext_op = 3'b011;
            end
            OPC_AUIPC: begin
                legal_s = 1'b1; dec_s.rd = bus.inst[11:7]; dec_s.rf_we = 1'b1;
                dec_s.alua_pc = 1'b1; dec_s.alub_sel = 1'b1; dec_s.sext_op = 3'b011;
            end
            OPC_JAL: begin
                legal_s = 1'b1; dec_s.rd = bus.inst[11:7]; dec_s.rf_we = 1'b1;
                dec_s.npc_op = 2'b10; dec_s.wd_sel = 2'b01; dec_s.sext_op = 3'b100;
            end
            OPC_JALR: begin
                legal_s = (f3_s == 3'b000);
                dec_s.rd = bus.inst[11:7]; dec_s.rs1 = bus.inst[19:15]; dec_s.rf_we = 1'b1;
                dec_s.npc_op = 2'b11; dec_s.wd_sel = 2'b01; dec_s.alub_sel = 1'b1;
            end
            OPC_BRANCH: begin
                legal_s = (f3_s != 3'b010) && (f3_s != 3'b011);
                dec_s.rs1 = bus.inst[19:15]; dec_s.rs2 = bus.inst[24:20];
                dec_s.npc_op = 2'b01; dec_s.branch = 1'b1; dec_s.br_type = f3_s;
                dec_s.alu_op = ALU_SUB; dec_s.sext_op = 3'b010;
            end
            OPC_LOAD: begin
                legal_s = (f3_s != 3'b011) && (f3_s[2:1] != 2'b11);
                dec_s.rd = bus.inst[11:7]; dec_s.rs1 = bus.inst[19:15]; dec_s.rf_we = 1'b1;
                dec_s.mem_re = 1'b1; dec_s.wd_sel = 2'b10; dec_s.alub_sel = 1'b1;
                dec_s.mem_size = f3_s;
            end
            OPC_STORE: begin
                legal_s = (f3_s[2] == 1'b0) && (f3_s != 3'b011);
                dec_s.rs1 = bus.inst[19:15]; dec_s.rs2 = bus.inst[24:20];
                dec_s.mem_we = 1'b1; dec_s.alub_sel = 1'b1; dec_s.mem_size = f3_s;
                dec_s.sext_op = 3'b001;
            end
            OPC_OPIMM: begin
                dec_s.rd = bus.inst[11:7]; dec_s.rs1 = bus.inst[19:15]; dec_s.rf_we = 1'b1;
                dec_s.alub_sel = 1'b1; dec_s.alu_op = base_alu(f3_s);
                case (f3_s)
                    3'b001: legal_s = (f7_s == 7'b0000000);
                    3'b101: begin
                        legal_s = (f7_s == 7'b0000000) || (f7_s == 7'b0100000);
                        dec_s.alu_op = f7_s[5] ? ALU_SRA : ALU_SRL;
                    end
                    default: legal_s = 1'b1;
                endcase
            end
            OPC_OP: begin
                dec_s.rd = bus.inst[11:7]; dec_s.rs1 = bus.inst[19:15];
                dec_s.rs2 = bus.inst[24:20]; dec_s.rf_we = 1'b1;
                case (f7_s)
                    7'b0000000: begin legal_s = 1'b1; dec_s.alu_op = base_alu(f3_s); end
                    7'b0100000: begin
                        case (f3_s)
                            3'b000:  begin legal_s = 1'b1; dec_s.alu_op = ALU_SUB; end
                            3'b101:  begin legal_s = 1'b1; dec_s.alu_op = ALU_SRA; end
                            default: legal_s = 1'b0;
                        endcase
                    end
                    7'b0000001: begin
                        // MULHSU/MULHU have no ALU code and are rejected.
                        case (f3_s)
                            3'b000:  begin legal_s = (RV_M != 0); dec_s.alu_op = ALU_MUL;  end
                            3'b001:  begin legal_s = (RV_M != 0); dec_s.alu_op = ALU_MULH; end
                            3'b100:  begin legal_s = (RV_M != 0); dec_s.alu_op = ALU_DIV;  end
                            3'b101:  begin legal_s = (RV_M != 0); dec_s.alu_op = ALU_DIVU; end
                            3'b110:  begin legal_s = (RV_M != 0); dec_s.alu_op = ALU_REM;  end
                            3'b111:  begin legal_s = (RV_M != 0); dec_s.alu_op = ALU_REMU; end
                            default: legal_s = 1'b0;
                        endcase
                    end
                    default: legal_s = 1'b0;
                endcase
            end
            default: legal_s = 1'b0;
        endcase
        // Anything undecodable collapses to a clean NOP so no field carries junk.
        if (!legal_s) begin
            dec_s         = '0;
            dec_s.illegal = 1'b1;
        end else begin
            dec_s.illegal = 1'b0;
        end
        dec_s.pc    = bus.pc;
        dec_s.rf_we = dec_s.rf_we && (dec_s.rd != 5'd0);
    end

    // Load-use: the registered load's destination is read by the incoming word.
    assign hz_s = valid_r && bun_r.mem_re && (bun_r.rd != 5'd0) && bus.in_valid &&
                  ((dec_s.rs1 == bun_r.rd) || (dec_s.rs2 == bun_r.rd));

    assign bus.in_ready = !bus.flush && !hz_s && (!valid_r || bus.out_ready);

    // ID/EX register: flush beats everything, then load/bubble, else hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= 1'b0;
            bun_r   <= '0;
            err_r   <= 1'b0;
            cnt_r   <= {CNT_W{1'b0}};
        end else if (bus.flush) begin
            valid_r <= 1'b0;
            bun_r   <= '0;
        end else if (!valid_r || bus.out_ready) begin
            if (bus.in_valid && !hz_s) begin
                valid_r <= 1'b1;
                bun_r   <= dec_s;
                err_r   <= err_r | dec_s.illegal;
            end else begin
                valid_r <= 1'b0;
                bun_r   <= '0;
                if (hz_s && (cnt_r != {CNT_W{1'b1}})) begin
                    cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    cnt_r <= cnt_r;
                end
            end
        end else begin
            valid_r <= valid_r;
            bun_r   <= bun_r;
        end
    end

    assign bus.out_valid    = valid_r;
    assign bus.out_pc       = bun_r.pc;
    assign bus.out_rs1      = bun_r.rs1;
    assign bus.out_rs2      = bun_r.rs2;
    assign bus.out_rd       = bun_r.rd;
    assign bus.out_npc_op   = bun_r.npc_op;
    assign bus.out_rf_we    = bun_r.rf_we;
    assign bus.out_wd_sel   = bun_r.wd_sel;
    assign bus.out_alua_pc  = bun_r.alua_pc;
    assign bus.out_sext_op  = bun_r.sext_op;
    assign bus.out_alu_op   = bun_r.alu_op;
    assign bus.out_alub_sel = bun_r.alub_sel;
    assign bus.out_branch   = bun_r.branch;
    assign bus.out_br_type  = bun_r.br_type;
    assign bus.out_mem_re   = bun_r.mem_re;
    assign bus.out_mem_we   = bun_r.mem_we;
    assign bus.out_mem_size = bun_r.mem_size;
    assign bus.out_illegal  = bun_r.illegal;
    assign bus.err_sticky   = err_r;
    assign bus.bubble_cnt   = cnt_r;
endmodule
